// File: rtl/gf_mul_pkg.sv
// Shared parameters, state encoding and sizing helpers for the GF(2^M) digit-serial multiplier.
package gf_mul_pkg;

  localparam int unsigned DEF_M   = 16;
  localparam int unsigned DEF_D   = 4;
  localparam int unsigned DEF_LAT = 2;

  function automatic int unsigned n_digits(input int unsigned m, input int unsigned d);
    return (m + d - 1) / d;
  endfunction

  // Never returns zero so a counter for a terminal count of 0 still has one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return ($clog2(v) < 1) ? 1 : int'($clog2(v));
  endfunction

  localparam int unsigned DEF_N = n_digits(DEF_M, DEF_D);

  // x^16 + x^5 + x^3 + x + 1
  localparam logic [16:0] POLY = 17'h1002B;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FEED  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StFeed  = ST_FEED,
    StDrain = ST_DRAIN,
    StHold  = ST_HOLD
  } state_e;

endpackage

// File: rtl/gf_dsmul_ctrl_if.sv
// Operand and result valid/ready bus of the multiplier sequencer.
interface gf_dsmul_ctrl_if #(
    parameter int unsigned M = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] in_a;
    logic [M-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out_c;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_c
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_c
    );
endinterface

// File: rtl/gf_digit_sreg.sv
// Parallel-load shifter presenting its top D bits as the current digit, shifting left by D.
module gf_digit_sreg #(
    parameter int unsigned W = 16,
    parameter int unsigned D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic [D-1:0] dout_digit
);
    logic [W-1:0] sreg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
        end else if (load) begin
            sreg_q <= din;
        end else if (shift) begin
            sreg_q <= sreg_q << D;
        end
    end

    assign dout_digit = sreg_q[W-1 -: D];
endmodule

// File: rtl/gf_dsmul_ctrl.sv
// Sequencer for a digit-serial GF(2^M) systolic multiplier: feeds B MSB digit first,
// waits out the array latency, then holds the captured product on a valid/ready port.
module gf_dsmul_ctrl
    import gf_mul_pkg::*;
#(
    parameter int unsigned M   = DEF_M,
    parameter int unsigned D   = DEF_D,
    parameter int unsigned LAT = DEF_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    gf_dsmul_ctrl_if.slave       bus,
    output logic                 arr_clr,
    output logic                 arr_en,
    output logic                 arr_dvalid,
    output logic [M-1:0]         arr_a,
    output logic [D-1:0]         arr_digit,
    input  logic [M-1:0]         arr_c
);
    localparam int unsigned N  = n_digits(M, D);
    localparam int unsigned W  = N * D;
    localparam int unsigned NW = clog2_min1(N + 1);
    localparam int unsigned LW = clog2_min1(LAT + 1);

    state_e        state_q, state_d;
    logic [NW-1:0] dig_q, dig_d;
    logic [LW-1:0] drn_q, drn_d;
    logic [M-1:0]  arr_a_q;
    logic [M-1:0]  out_c_q;
    logic [D-1:0]  sreg_digit;
    logic          in_ready;
    logic          accept;
    logic          capture;
    logic          shift;

    // Ready may look at out_ready so a result and new operands can swap in the same cycle.
    assign in_ready = (state_q == StIdle) | ((state_q == StHold) & bus.out_ready);
    assign accept   = bus.in_valid & in_ready & ~rst;

    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        drn_d   = drn_q;
        capture = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StFeed;
                    dig_d   = '0;
                end
            end
            StFeed: begin
                shift = 1'b1;
                if (dig_q == NW'(N - 1)) begin
                    dig_d = '0;
                    if (LAT == 0) begin
                        capture = 1'b1;
                        state_d = StHold;
                    end else begin
                        drn_d   = '0;
                        state_d = StDrain;
                    end
                end else begin
                    dig_d = dig_q + NW'(1);
                end
            end
            StDrain: begin
                if ((LW + 1)'(drn_q) + (LW + 1)'(1) == (LW + 1)'(LAT)) begin
                    capture = 1'b1;
                    drn_d   = '0;
                    state_d = StHold;
                end else begin
                    drn_d = drn_q + LW'(1);
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    state_d = accept ? StFeed : StIdle;
                    dig_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            dig_q   <= '0;
            drn_q   <= '0;
            arr_a_q <= '0;
            out_c_q <= '0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            drn_q   <= drn_d;
            if (accept) begin
                arr_a_q <= bus.in_a;
            end
            if (capture) begin
                out_c_q <= arr_c;
            end
        end
    end

    gf_digit_sreg #(
        .W (W),
        .D (D)
    ) u_sreg (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .shift      (shift),
        .din        (W'(bus.in_b)),
        .dout_digit (sreg_digit)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == StHold);
    assign bus.out_c     = out_c_q;

    assign arr_clr    = accept;
    assign arr_en     = (state_q == StFeed) | (state_q == StDrain);
    assign arr_dvalid = (state_q == StFeed);
    assign arr_digit  = (state_q == StFeed) ? sreg_digit : '0;
    assign arr_a      = arr_a_q;
endmodule
